cache_op_ctrl: RTL

Parametrised request/response controller for the key-value cache. It accepts one operation at a time (READ, UPSERT, DELETE) over a valid/ready handshake and sequences the lookup and execute phases against the entry memory. It returns a status code over a second valid/ready handshake. It sits between the host interface block and the entry memory array and replaces the single-shot controller with one that owns slot allocation and full-cache handling.

---
 rtl/ctrl_types_pkg.sv | 38 +++
 rtl/free_slot_finder.sv | 17 +
 rtl/cache_op_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_types_pkg.sv
// rtl/ctrl_types_pkg.sv - shared enums and one-hot helper for the cache operation controller
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_READ   = 2'd1,
    OP_UPSERT = 2'd2,
    OP_DELETE = 2'd3
  } operation_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_MISS   = 2'd1,
    ST_FULL   = 2'd2,
    ST_BAD_OP = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } ctrl_state_e;

  localparam int MAX_ENTRIES = 256;
  localparam int MAX_IDX_W   = 8;

  // Callers zero-extend their vector to MAX_ENTRIES and truncate the result to their index width.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_bin(input logic [MAX_ENTRIES-1:0] oh);
    logic [MAX_IDX_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (oh[i]) bin = bin | MAX_IDX_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/free_slot_finder.sv
// rtl/free_slot_finder.sv - lowest-index free slot priority encoder (one-hot out)
module free_slot_finder #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic [NUM_ENTRIES-1:0] used,
  output logic [NUM_ENTRIES-1:0] free_slot,
  output logic                   any_free
);

  logic [NUM_ENTRIES-1:0] used_inc;

  // Adding one ripples through the trailing ones and lands on the lowest zero.
  assign used_inc  = used + NUM_ENTRIES'(1);
  assign free_slot = ~used & used_inc;
  assign any_free  = ~&used;

endmodule

// File: rtl/cache_op_ctrl.sv
// rtl/cache_op_ctrl.sv - key-value cache request/response controller; CACHE_OP_CTRL_EVICT_EN enables round-robin eviction
module cache_op_ctrl
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_status,
  output logic [IDX_W-1:0]       resp_idx,
  input  logic                   mem_hit,
  input  logic [NUM_ENTRIES-1:0] mem_hit_idx,
  input  logic [NUM_ENTRIES-1:0] mem_used,
  output logic                   mem_select,
  output logic                   mem_write,
  output logic                   mem_delete,
  output logic [NUM_ENTRIES-1:0] mem_idx,
  output logic [IDX_W:0]         occupancy
);

  ctrl_state_e            state, state_nx;
  operation_e             op_q;
  logic                   hit_q, any_free_q;
  logic [NUM_ENTRIES-1:0] hit_idx_q, free_q;
  status_e                status_q, exec_status;
  logic [IDX_W-1:0]       idx_q, exec_idx;
  logic [NUM_ENTRIES-1:0] free_slot;
  logic                   any_free;
  logic [IDX_W:0]         used_count;
  logic                   evict;

  free_slot_finder #(.NUM_ENTRIES(NUM_ENTRIES)) u_free (
    .used      (mem_used),
    .free_slot (free_slot),
    .any_free  (any_free)
  );

`ifdef CACHE_OP_CTRL_EVICT_EN
  logic [NUM_ENTRIES-1:0] victim_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     victim_q <= NUM_ENTRIES'(1);
    else if (evict) victim_q <= {victim_q[NUM_ENTRIES-2:0], victim_q[NUM_ENTRIES-1]};
  end
`endif

  always_comb begin
    used_count = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) used_count = used_count + (IDX_W+1)'(mem_used[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_select  = 1'b0;
    mem_write   = 1'b0;
    mem_delete  = 1'b0;
    mem_idx     = '0;
    exec_status = ST_OK;
    exec_idx    = '0;
    evict       = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = (operation_e'(req_op) == OP_NOP) ? S_RESP : S_LOOKUP;
      end
      S_LOOKUP: begin
        mem_select = 1'b1;
        state_nx   = S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_RESP;
        case (op_q)
          OP_READ: begin
            if (hit_q) begin
              mem_select = 1'b1;
              mem_idx    = hit_idx_q;
              exec_idx   = IDX_W'(onehot_to_bin(MAX_ENTRIES'(hit_idx_q)));
            end else begin
              exec_status = ST_MISS;
            end
          end
          OP_UPSERT: begin
            if (hit_q) begin
              mem_write = 1'b1;
              mem_idx   = hit_idx_q;
              exec_idx  = IDX_W'(onehot_to_bin(MAX_ENTRIES'(hit_idx_q)));
            end else if (any_free_q) begin
              mem_write = 1'b1;
              mem_idx   = free_q;
              exec_idx  = IDX_W'(onehot_to_bin(MAX_ENTRIES'(free_q)));
            end else begin
`ifdef CACHE_OP_CTRL_EVICT_EN
              mem_write = 1'b1;
              mem_idx   = victim_q;
              exec_idx  = IDX_W'(onehot_to_bin(MAX_ENTRIES'(victim_q)));
              evict     = 1'b1;
`else
              exec_status = ST_FULL;
`endif
            end
          end
          OP_DELETE: begin
            if (hit_q) begin
              mem_delete = 1'b1;
              mem_idx    = hit_idx_q;
              exec_idx   = IDX_W'(onehot_to_bin(MAX_ENTRIES'(hit_idx_q)));
            end else begin
              exec_status = ST_MISS;
            end
          end
          default: exec_status = ST_BAD_OP;
        endcase
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NOP;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      free_q     <= '0;
      any_free_q <= 1'b0;
      status_q   <= ST_OK;
      idx_q      <= '0;
      occupancy  <= '0;
    end else begin
      occupancy <= used_count;
      if (state == S_IDLE && req_valid) begin
        op_q <= operation_e'(req_op);
        if (operation_e'(req_op) == OP_NOP) begin
          status_q <= ST_BAD_OP;
          idx_q    <= '0;
        end
      end
      if (state == S_LOOKUP) begin
        hit_q      <= mem_hit;
        hit_idx_q  <= mem_hit_idx;
        free_q     <= free_slot;
        any_free_q <= any_free;
      end
      if (state == S_EXEC) begin
        status_q <= exec_status;
        idx_q    <= exec_idx;
      end
    end
  end

  assign resp_status = status_q;
  assign resp_idx    = idx_q;

  // Memory must return a one-hot index whenever it reports a hit.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_LOOKUP && mem_hit) |-> $onehot(mem_hit_idx));
  assert property (@(posedge clk) disable iff (!rst_n) !(mem_write && mem_delete));

endmodule
